// File: rtl/adc_sar_control_param_if.sv
// Result handshake bundle between the SAR controller and the result consumer.
interface adc_sar_control_param_if #(
  parameter int unsigned MATRIX_BITS = 12
);
  logic [MATRIX_BITS-1:0] result_out;
  logic                   result_valid_out;
  logic                   result_ready_in;
  logic                   saturated_out;
  logic                   overrun_out;

  // Controller side drives the result, consumer drives ready
  modport master (
    output result_out,
    output result_valid_out,
    output saturated_out,
    output overrun_out,
    input  result_ready_in
  );

  modport slave (
    input  result_out,
    input  result_valid_out,
    input  saturated_out,
    input  overrun_out,
    output result_ready_in
  );
endinterface

// File: rtl/adc_sar_control_param.sv
// SAR conversion sequencer: sample phase, redundant-weight successive approximation,
// majority averaging on the final steps, single-shot/continuous modes, result handshake.
module adc_sar_control_param #(
  parameter int unsigned                       MATRIX_BITS   = 12,
  parameter int unsigned                       N_STEPS       = 15,
  parameter logic [N_STEPS*MATRIX_BITS-1:0]    WEIGHTS       = {
    12'd1,   12'd2,   12'd4,   12'd6,   12'd9,   12'd15,  12'd25, 12'd41,
    12'd67,  12'd110, 12'd180, 12'd295, 12'd486, 12'd806, 12'd2048},
  parameter int unsigned                       AVG_STEPS     = 4,
  parameter int unsigned                       SAMPLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   comparator_in,
  input  logic [2:0]             avg_control_in,
  input  logic                   continuous_in,
  input  logic                   start_in,
  output logic                   sample_out,
  output logic                   sample_out_n,
  output logic                   enable_loop_out,
  output logic [MATRIX_BITS-1:0] pswitch_out,
  output logic [MATRIX_BITS-1:0] nswitch_out,
  output logic                   busy_out,
  adc_sar_control_param_if.master res_if
);

  localparam int unsigned DATA_W    = MATRIX_BITS + 1;
  localparam int unsigned STEP_W    = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int unsigned SCNT_W    = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int unsigned AVG_W     = 5;
  localparam int unsigned SUM_W     = 6;
  localparam int unsigned FIRST_AVG = N_STEPS - AVG_STEPS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DATA_W-1:0]      r_data;
  logic [STEP_W-1:0]      r_step;
  logic [SCNT_W-1:0]      r_scnt;
  logic [AVG_W-1:0]       r_avg_n;
  logic [AVG_W-1:0]       r_cnt;
  logic [SUM_W-1:0]       r_sum;
  logic [MATRIX_BITS-1:0] r_result;
  logic                   r_valid;
  logic                   r_sat;
  logic                   r_overrun;
  logic                   r_sample;
  logic                   r_sample_n;
  logic                   r_enable;
  logic                   r_busy;

  logic [MATRIX_BITS-1:0] w_weight;
  logic                   w_is_avg;
  logic [SUM_W-1:0]       w_sum_tot;
  logic [SUM_W-1:0]       w_half;
  logic                   w_step_end;
  logic                   w_decide;
  logic                   w_done;
  logic [DATA_W-1:0]      w_data_acc;
  logic                   w_new_sat;
  logic [MATRIX_BITS-1:0] w_new_result;
  logic                   w_enter_sample;

  // Number of comparisons per averaged step selected by avg_control_in
  function automatic logic [AVG_W-1:0] f_avg_count(input logic [2:0] sel);
    case (sel)
      3'd0:    f_avg_count = 5'd1;
      3'd1:    f_avg_count = 5'd3;
      3'd2:    f_avg_count = 5'd7;
      3'd3:    f_avg_count = 5'd15;
      3'd4:    f_avg_count = 5'd31;
      default: f_avg_count = 5'd1;
    endcase
  endfunction

  assign w_weight     = WEIGHTS[int'(r_step)*MATRIX_BITS +: MATRIX_BITS];
  assign w_is_avg     = (int'(r_step) >= int'(FIRST_AVG));
  assign w_sum_tot    = r_sum + SUM_W'(comparator_in);
  assign w_half       = SUM_W'(({1'b0, r_avg_n} + 6'd1) >> 1);
  assign w_data_acc   = r_data + (w_decide ? DATA_W'(w_weight) : DATA_W'(0));
  assign w_new_sat    = w_data_acc[DATA_W-1];
  assign w_new_result = w_new_sat ? {MATRIX_BITS{1'b1}} : w_data_acc[MATRIX_BITS-1:0];
  assign w_enter_sample = (w_state_nxt == S_SAMPLE) && (r_state != S_SAMPLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and per-step decision
  always_comb begin
    w_state_nxt = r_state;
    w_step_end  = 1'b0;
    w_decide    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in || continuous_in) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (r_scnt == SCNT_W'(SAMPLE_CYCLES - 1)) w_state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (!w_is_avg) begin
          w_step_end = 1'b1;
          w_decide   = comparator_in;
        end else if (r_cnt == r_avg_n - AVG_W'(1)) begin
          w_step_end = 1'b1;
          w_decide   = (w_sum_tot >= w_half);
        end
        if (w_step_end && (r_step == STEP_W'(N_STEPS - 1))) begin
          w_done      = 1'b1;
          w_state_nxt = continuous_in ? S_SAMPLE : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample/step counters, averaging accumulators and approximation data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_step  <= '0;
      r_scnt  <= '0;
      r_avg_n <= AVG_W'(1);
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_SAMPLE: r_scnt <= r_scnt + SCNT_W'(1);
        S_CONVERT: begin
          if (w_step_end) begin
            r_data <= w_data_acc;
            r_step <= r_step + STEP_W'(1);
            r_cnt  <= '0;
            r_sum  <= '0;
          end else begin
            r_cnt <= r_cnt + AVG_W'(1);
            r_sum <= w_sum_tot;
          end
        end
        default: ;
      endcase
      if (w_enter_sample) begin
        r_avg_n <= f_avg_count(avg_control_in);
        r_scnt  <= '0;
        r_data  <= '0;
      end
      if ((r_state == S_SAMPLE) && (w_state_nxt == S_CONVERT)) begin
        r_step <= '0;
        r_cnt  <= '0;
        r_sum  <= '0;
      end
    end
  end

  // Result register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_sat     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (r_valid && !res_if.result_ready_in) begin
        r_overrun <= 1'b1;
      end else begin
        r_result <= w_new_result;
        r_sat    <= w_new_sat;
        r_valid  <= 1'b1;
      end
    end else if (res_if.result_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  // Phase outputs registered from the next state so they track r_state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample   <= 1'b0;
      r_sample_n <= 1'b1;
      r_enable   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sample   <= (w_state_nxt == S_SAMPLE);
      r_sample_n <= (w_state_nxt != S_SAMPLE);
      r_enable   <= (w_state_nxt == S_CONVERT);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign sample_out      = r_sample;
  assign sample_out_n    = r_sample_n;
  assign enable_loop_out = r_enable;
  assign busy_out        = r_busy;
  assign nswitch_out     = (r_state == S_CONVERT) ? MATRIX_BITS'(r_data + DATA_W'(w_weight))
                                                  : '0;
  assign pswitch_out     = ~nswitch_out;

  assign res_if.result_out       = r_result;
  assign res_if.result_valid_out = r_valid;
  assign res_if.saturated_out    = r_sat;
  assign res_if.overrun_out      = r_overrun;

endmodule

// File: tb/tb_adc_sar_control_param.sv
// Bench for adc_sar_control_param: directed sequence with randomized comparator streams
// checked against a step-level reference model.
module tb_adc_sar_control_param;
  localparam int unsigned MB = 12;
  localparam logic [15*MB-1:0] W_SAT_FLAT = {
    12'd1,   12'd1,   12'd1,   12'd2,   12'd4,   12'd8,    12'd16,  12'd32,
    12'd64,  12'd128, 12'd256, 12'd512, 12'd903, 12'd1024, 12'd2048};

  int w_def [15] = '{2048, 806, 486, 295, 180, 110, 67, 41, 25, 15, 9, 6, 4, 2, 1};
  int w_sat [15] = '{2048, 1024, 903, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1, 1};

  logic clk = 1'b0;
  logic rst;
  logic comp;
  logic [2:0] avg;
  logic cont;
  logic start_d, start_s;
  logic sample_d, sample_n_d, en_d, busy_d;
  logic sample_s, sample_n_s, en_s, busy_s;
  logic [MB-1:0] ps_d, ns_d, ps_s, ns_s;

  adc_sar_control_param_if #(.MATRIX_BITS(MB)) rif ();
  adc_sar_control_param_if #(.MATRIX_BITS(MB)) rif_s ();

  adc_sar_control_param dut (
    .clk(clk), .rst(rst), .comparator_in(comp), .avg_control_in(avg),
    .continuous_in(cont), .start_in(start_d), .sample_out(sample_d),
    .sample_out_n(sample_n_d), .enable_loop_out(en_d), .pswitch_out(ps_d),
    .nswitch_out(ns_d), .busy_out(busy_d), .res_if(rif)
  );

  adc_sar_control_param #(.WEIGHTS(W_SAT_FLAT)) dut_sat (
    .clk(clk), .rst(rst), .comparator_in(comp), .avg_control_in(avg),
    .continuous_in(1'b0), .start_in(start_s), .sample_out(sample_s),
    .sample_out_n(sample_n_s), .enable_loop_out(en_s), .pswitch_out(ps_s),
    .nswitch_out(ns_s), .busy_out(busy_s), .res_if(rif_s)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit comp_q [$];
  int ns_q [$];
  int exp_res, exp_sat, exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: per-step comparison count, majority vote, weight accumulation
  task automatic plan(input int which, input int avg_sel, input int mode);
    int n, data, cyc, ones, w;
    bit b;
    n = (avg_sel <= 4) ? ((1 << (avg_sel + 1)) - 1) : 1;
    comp_q.delete();
    ns_q.delete();
    data = 0;
    for (int s = 0; s < 15; s++) begin
      cyc  = (s >= 11) ? n : 1;
      w    = which ? w_sat[s] : w_def[s];
      ones = 0;
      for (int c = 0; c < cyc; c++) begin
        case (mode)
          0:       b = 1'b1;
          1:       b = 1'b0;
          2:       b = 1'($urandom_range(0, 1));
          default: b = (s < 11) ? 1'b1 : (c < ((s % 2 == 1) ? 4 : 3));
        endcase
        comp_q.push_back(b);
        ns_q.push_back((data + w) % 4096);
        ones += int'(b);
      end
      if (2 * ones > cyc) data += w;
    end
    exp_sat = (data > 4095) ? 1 : 0;
    exp_res = exp_sat ? 4095 : data;
    exp_lat = 1 + comp_q.size();
  endtask

  // Called at the first negedge after the SAMPLE entry edge; returns at the negedge
  // following the completion edge.
  task automatic run_conv(input int which, input bit ready_at_end);
    int j, k;
    bit done;
    logic [MB-1:0] ns, ps;
    logic en, so, son, bz;
    j = 1;
    done = 0;
    while (!done) begin
      ns  = which ? ns_s : ns_d;
      ps  = which ? ps_s : ps_d;
      en  = which ? en_s : en_d;
      so  = which ? sample_s : sample_d;
      son = which ? sample_n_s : sample_n_d;
      bz  = which ? busy_s : busy_d;
      comp = 1'b0;
      if (j == 1) begin
        chk("sample_out", so, 1);
        chk("sample_out_n", son, 0);
        chk("busy_sample", bz, 1);
        chk("nswitch_sample", ns, 0);
      end else if (!en) begin
        done = 1;
        chk("latency", j - 1, exp_lat);
      end else begin
        k = j - 2;
        if (k < comp_q.size()) begin
          comp = comp_q[k];
          chk("nswitch", ns, ns_q[k]);
          chk("pswitch", ps, (~ns_q[k]) & 'hFFF);
          if (which) rif_s.result_ready_in = ready_at_end && (k == comp_q.size() - 1);
          else       rif.result_ready_in   = ready_at_end && (k == comp_q.size() - 1);
        end
      end
      if (!done) begin
        if (j > 3000) begin
          chk("timeout", j, exp_lat);
          done = 1;
        end else begin
          @(negedge clk);
          j++;
        end
      end
    end
    rif.result_ready_in   = 1'b0;
    rif_s.result_ready_in = 1'b0;
  endtask

  task automatic start_single();
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
  endtask

  task automatic check_result(input string tag, input int res, input int sat, input int ovr);
    chk({tag, "_valid"}, rif.result_valid_out, 1);
    chk({tag, "_result"}, rif.result_out, res);
    chk({tag, "_sat"}, rif.saturated_out, sat);
    chk({tag, "_overrun"}, rif.overrun_out, ovr);
  endtask

  task automatic ack();
    rif.result_ready_in = 1'b1;
    @(negedge clk);
    rif.result_ready_in = 1'b0;
    chk("ack_valid_low", rif.result_valid_out, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy_d, 0);
    chk({tag, "_sample"}, sample_d, 0);
    chk({tag, "_sample_n"}, sample_n_d, 1);
    chk({tag, "_enable"}, en_d, 0);
    chk({tag, "_nswitch"}, ns_d, 0);
    chk({tag, "_pswitch"}, ps_d, 'hFFF);
    chk({tag, "_valid"}, rif.result_valid_out, 0);
    chk({tag, "_result"}, rif.result_out, 0);
    chk({tag, "_sat"}, rif.saturated_out, 0);
    chk({tag, "_overrun"}, rif.overrun_out, 0);
  endtask

  initial begin
    int a, r1;
    rst = 1'b1; comp = 1'b0; avg = 3'd0; cont = 1'b0; start_d = 1'b0; start_s = 1'b0;
    rif.result_ready_in = 1'b0;
    rif_s.result_ready_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");

    // All-ones comparator, no averaging
    avg = 3'd0;
    plan(0, 0, 0);
    start_single();
    run_conv(0, 0);
    chk("lat_noavg", exp_lat, 16);
    check_result("ones", 4095, 0, 0);
    chk("idle_after", busy_d, 0);
    ack();

    // All-zeros comparator: full weight sweep on nswitch
    plan(0, 0, 1);
    start_single();
    run_conv(0, 0);
    check_result("zeros", 0, 0, 0);
    ack();

    // 7-sample averaging: 4-of-7 decides 1, 3-of-7 decides 0
    avg = 3'd2;
    plan(0, 2, 3);
    start_single();
    run_conv(0, 0);
    chk("lat_avg7", exp_lat, 40);
    check_result("avg7", 4090, 0, 0);
    ack();

    // Randomized comparator and averaging selections
    for (int t = 0; t < 6; t++) begin
      a = int'($urandom_range(0, 7));
      avg = 3'(a);
      plan(0, a, 2);
      start_single();
      run_conv(0, 0);
      check_result("rand", exp_res, exp_sat, 0);
      ack();
    end

    // Ready in the completion cycle replaces a pending result without overrun
    avg = 3'd1;
    plan(0, 1, 2);
    start_single();
    run_conv(0, 0);
    check_result("pend", exp_res, exp_sat, 0);
    plan(0, 1, 0);
    start_single();
    run_conv(0, 1);
    check_result("replace", 4095, 0, 0);
    ack();

    // Saturating weight set (sum 5000)
    avg = 3'd0;
    plan(1, 0, 0);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    run_conv(1, 0);
    chk("sat_valid", rif_s.result_valid_out, 1);
    chk("sat_result", rif_s.result_out, 4095);
    chk("sat_flag", rif_s.saturated_out, 1);

    // Continuous mode, consumer stalled: second result dropped, overrun set
    avg = 3'd0;
    plan(0, 0, 0);
    cont = 1'b1;
    @(negedge clk);
    run_conv(0, 0);
    check_result("cont1", 4095, 0, 0);
    plan(0, 0, 1);
    cont = 1'b0;
    run_conv(0, 0);
    check_result("cont2", 4095, 0, 1);
    chk("cont2_idle", busy_d, 0);
    ack();
    chk("overrun_sticky", rif.overrun_out, 1);

    // Reset during step 5 of a conversion
    plan(0, 0, 0);
    comp = 1'b1;
    start_single();
    repeat (6) @(negedge clk);
    chk("mid_enable", en_d, 1);
    chk("mid_nswitch", ns_d, ns_q[5]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    comp = 1'b0;
    check_reset("midreset");

    // Clean conversion after the mid-conversion reset
    r1 = int'($urandom_range(0, 3));
    avg = 3'(r1);
    plan(0, r1, 2);
    start_single();
    run_conv(0, 0);
    check_result("post_reset", exp_res, exp_sat, 0);
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
